// File: rtl/pmem_pkg.sv
// ============================================================================
// Module      : pmem_pkg
// Description : Shared types and constants for the program-memory loader.
//               FSM state encoding, default geometry, memory depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmem_pkg;

    localparam int PMEM_ADDR_W = 6;
    localparam int PMEM_DATA_W = 32;
    localparam int PMEM_DEPTH  = 1 << PMEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } pmem_state_t;

endpackage

`default_nettype wire

// File: rtl/pmem_loader.sv
// ============================================================================
// Module      : pmem_loader
// Description : Streams a host word sequence into program memory while holding
//               the core in reset, optionally re-reads it and compares a
//               modulo-2^DATA_W checksum before releasing the core.
//               Optional feature macro: PMEM_LOADER_VERIFY_EN (read-back
//               verification pass and checksum registers).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_loader
    import pmem_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int DATA_W = PMEM_DATA_W
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              pmem_we,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [DATA_W-1:0] pmem_wd,
    input  logic [DATA_W-1:0] pmem_rd,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Largest legal word_count: the full memory depth.
    localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};

`ifdef PMEM_LOADER_VERIFY_EN
    localparam pmem_state_t c_after_load = VERIFY;
`else
    localparam pmem_state_t c_after_load = DONE;
`endif

    pmem_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic              r_err;

    logic              w_beat;
    logic              w_last;
    logic              w_start_ok;
    logic [ADDR_W:0]   w_wc_m1;

    assign w_beat     = (r_state == LOAD) && s_valid;
    assign w_last     = (r_addr == r_last);
    assign w_start_ok = (word_count != '0) && (word_count <= c_depth);
    assign w_wc_m1    = word_count - c_one;

`ifdef PMEM_LOADER_VERIFY_EN
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] r_rdsum;
    logic [DATA_W-1:0] w_rdsum_next;

    assign w_rdsum_next = r_rdsum + pmem_rd;
`else
    // Read data is only consumed by the verification pass.
    logic w_unused_rd;
    assign w_unused_rd = ^pmem_rd;
`endif

    // Control FSM: start acceptance, write addressing, verification pass.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_last     <= '0;
            r_err      <= 1'b0;
`ifdef PMEM_LOADER_VERIFY_EN
            r_checksum <= '0;
            r_rdsum    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_addr     <= '0;
`ifdef PMEM_LOADER_VERIFY_EN
                        r_checksum <= '0;
                        r_rdsum    <= '0;
`endif
                        if (w_start_ok) begin
                            r_state <= LOAD;
                            r_last  <= w_wc_m1[ADDR_W-1:0];
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_beat) begin
`ifdef PMEM_LOADER_VERIFY_EN
                        r_checksum <= r_checksum + s_data;
`endif
                        // Counter returns to zero rather than wrapping so the
                        // verify pass starts from the first word.
                        if (w_last) begin
                            r_addr  <= '0;
                            r_state <= c_after_load;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                        end
                    end
                end
`ifdef PMEM_LOADER_VERIFY_EN
                VERIFY: begin
                    r_rdsum <= w_rdsum_next;
                    if (w_last) begin
                        r_addr  <= '0;
                        r_state <= DONE;
                        r_err   <= (w_rdsum_next != r_checksum);
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    // Memory port and status decode from the registered state.
    always_comb begin
        s_ready   = (r_state == LOAD);
        pmem_we   = w_beat;
        pmem_addr = (w_beat || (r_state == VERIFY)) ? r_addr : '0;
        pmem_wd   = w_beat ? s_data : '0;
        busy      = (r_state == LOAD) || (r_state == VERIFY);
        done      = (r_state == DONE);
        err       = r_err;
        core_hold = !((r_state == DONE) && !r_err);
    end

endmodule

`default_nettype wire

// File: tb/tb_pmem_loader.sv
// ============================================================================
// Module      : tb_pmem_loader
// Description : Self-checking bench for pmem_loader. Expected writes are
//               queued as beats are driven and popped when the DUT writes.
//               Honors PMEM_LOADER_VERIFY_EN for latency and corruption cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmem_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = pmem_pkg::PMEM_DEPTH;

`ifdef PMEM_LOADER_VERIFY_EN
    localparam int c_verify = 1;
`else
    localparam int c_verify = 0;
`endif

    logic              sysclk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              pmem_we;
    logic [ADDR_W-1:0] pmem_addr;
    logic [DATA_W-1:0] pmem_wd;
    logic [DATA_W-1:0] pmem_rd;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    int checks;
    int errors;
    int wr_count;
    int addr_exp;
    logic corrupt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    logic [ADDR_W+DATA_W-1:0] e;

    pmem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .pmem_we    (pmem_we),
        .pmem_addr  (pmem_addr),
        .pmem_wd    (pmem_wd),
        .pmem_rd    (pmem_rd),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Program memory model; optional corruption of address 1.
    always @(posedge sysclk) begin
        if (pmem_we)
            mem[pmem_addr] <= (corrupt && pmem_addr == 6'd1) ? ~pmem_wd : pmem_wd;
    end
    assign pmem_rd = mem[pmem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge sysclk) begin
        if (rst_n && pmem_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(pmem_addr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(pmem_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
                chk("wr_data", 64'(pmem_wd), 64'(e[DATA_W-1:0]));
            end
        end
    end

    task automatic do_start(input logic [ADDR_W:0] wc);
        @(posedge sysclk); #1;
        start = 1'b1;
        word_count = wc;
        addr_exp = 0;
        wr_count = 0;
        @(posedge sysclk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int gap);
        s_valid = 1'b0;
        repeat (gap) begin @(posedge sysclk); #1; end
        s_valid = 1'b1;
        s_data = d;
        exp_q.push_back({addr_exp[ADDR_W-1:0], d});
        addr_exp++;
        @(posedge sysclk); #1;
        s_valid = 1'b0;
        s_data = '0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic exp_err,
                             input int exp_writes);
        int n;
        n = 0;
        while (!done && n < 300) begin @(posedge sysclk); #1; n++; end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_core_hold"}, 64'(core_hold), 64'(exp_err));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_addr_idle"}, 64'(pmem_addr), 64'd0);
        chk({tag, "_writes"}, 64'(wr_count), 64'(exp_writes));
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; wr_count = 0; addr_exp = 0; corrupt = 1'b0;
        rst_n = 1'b0; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
        #2;
        chk("rst_state", {57'd0, s_ready, pmem_we, busy, done, err, core_hold, |pmem_addr},
            64'b0000010);
        chk("rst_wd", 64'(pmem_wd), 64'd0);
        repeat (2) @(posedge sysclk);
        #1 rst_n = 1'b1;

        // Four words back-to-back.
        do_start(7'd4);
        chk("load_status", {61'd0, s_ready, busy, core_hold}, 64'b111);
        send(32'h1, 0); send(32'h2, 0); send(32'h3, 0); send(32'h4, 0);
        wait_done("b2b", 4 * c_verify, 1'b0, 4);

        // Three words with two-cycle gaps.
        do_start(7'd3);
        send(32'hA5A5_0001, 0); send(32'hA5A5_0002, 2); send(32'hA5A5_0003, 2);
        wait_done("gap", 3 * c_verify, 1'b0, 3);

        // Illegal counts, with s_valid held to provoke any stray write.
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        do_start(7'd0);
        chk("wc0_ready", 64'(s_ready), 64'd0);
        wait_done("wc0", 0, 1'b1, 0);
        do_start(7'd65);
        wait_done("wc65", 0, 1'b1, 0);
        s_valid = 1'b0; s_data = '0;

`ifdef PMEM_LOADER_VERIFY_EN
        // Corrupted read-back must fail verification.
        corrupt = 1'b1;
        do_start(7'd4);
        send(32'h10, 0); send(32'h20, 0); send(32'h30, 0); send(32'h40, 0);
        wait_done("corrupt", 4, 1'b1, 4);
        corrupt = 1'b0;
`endif

        // Asynchronous reset after two of eight beats.
        do_start(7'd8);
        send(32'h100, 0); send(32'h101, 0);
        #2;
        s_valid = 1'b1; s_data = 32'h5555_5555;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {57'd0, s_ready, pmem_we, busy, done, err, core_hold, |pmem_addr},
            64'b0000010);
        chk("arst_wd", 64'(pmem_wd), 64'd0);
        s_valid = 1'b0; s_data = '0;
        @(posedge sysclk); #1;
        rst_n = 1'b1;
        do_start(7'd8);
        for (int i = 0; i < 8; i++) send(32'h200 + 32'(i), (i == 5) ? 1 : 0);
        wait_done("after_rst", 8 * c_verify, 1'b0, 8);

        // Full-depth load of all-ones.
        do_start(7'd64);
        for (int i = 0; i < 64; i++) send(32'hFFFF_FFFF, 0);
        wait_done("full", 64 * c_verify, 1'b0, 64);
        chk("full_last_wr", 64'(mem[63]), 64'hFFFF_FFFF);

        // start outside IDLE/DONE is ignored.
        do_start(7'd2);
        start = 1'b1; word_count = 7'd0;
        @(posedge sysclk); #1;
        start = 1'b0;
        chk("ignore_start", 64'(busy), 64'd1);
        send(32'h77, 0); send(32'h88, 0);
        wait_done("ign", 2 * c_verify, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pmem_loader.md
PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 Parameter: ADDR_W, default 6, program-memory word-address width.
REQ-002 Parameter: DATA_W, default 32, program-memory word width.
REQ-003 sysclk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle load request; sampled only in IDLE and DONE.
REQ-006 word_count  in  ADDR_W+1  words to load; sampled on accepted start.
REQ-007 s_valid / s_data  in  1 / DATA_W  host word stream.
REQ-008 s_ready  out  1  loader accepts s_data this cycle.
REQ-009 pmem_we / pmem_addr / pmem_wd  out  1 / ADDR_W / DATA_W  write port to program memory.
REQ-010 pmem_rd  in  DATA_W  program-memory read data, combinational from pmem_addr (0-cycle).
REQ-011 core_hold  out  1  holds the MIPS core in reset while high.
REQ-012 busy / done / err  out  1 each  status for the AXI status register.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, VERIFY, DONE.
REQ-014 IDLE + start: word_count 1..2^ADDR_W -> LOAD next cycle, with addr counter=0 and checksum=0.
REQ-015 IDLE + start with word_count=0 or >2^ADDR_W -> DONE with err=1; no write issued.
REQ-016 In LOAD, s_ready=1; each beat (s_valid&s_ready) asserts pmem_we the same cycle, pmem_addr=counter, pmem_wd=s_data.
REQ-017 Each accepted beat increments the counter and adds s_data to checksum modulo 2^DATA_W.
REQ-018 s_valid low in LOAD inserts wait cycles; no write, state held.
REQ-019 Last beat (counter==word_count-1) -> VERIFY when verification is compiled in, else DONE; the counter never wraps.
REQ-020 VERIFY: pmem_we=0 and s_ready=0; over word_count cycles pmem_addr steps 0..word_count-1 and pmem_rd is summed.
REQ-021 VERIFY end -> DONE; err=1 when read sum != checksum, else err=0.
REQ-022 DONE: done=1, err held; start restarts per REQ-014/015 and clears done/err on the same edge.
REQ-023 busy=1 in LOAD and VERIFY; core_hold=1 in every state except DONE with err=0.
REQ-024 start outside IDLE/DONE SHALL be ignored; s_valid outside LOAD SHALL be ignored, with s_ready=0.
REQ-025 pmem_addr=0 and pmem_wd=0 whenever pmem_we=0 and not in VERIFY.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, counter=0, checksum=0, s_ready=0, pmem_we=0, pmem_addr=0, pmem_wd=0, busy=0, done=0, err=0, core_hold=1.
REQ-027 Reset mid-LOAD or mid-VERIFY SHALL abandon the operation; memory contents already written are left as-is.

Configuration
REQ-028 Macro PMEM_LOADER_VERIFY_EN: when defined, the VERIFY state and checksum logic are built per REQ-019..021.
REQ-029 When PMEM_LOADER_VERIFY_EN is undefined, LOAD goes directly to DONE, err is set only by REQ-015, and no checksum register is built.

Structure
REQ-030 Shared package pmem_pkg SHALL hold the FSM state enum, the ADDR_W/DATA_W defaults and a PMEM_DEPTH constant.
REQ-031 The design SHALL be a single module with no sub-modules; the checksum accumulator stays inline.

Verification
REQ-032 start, word_count=4, words 0x1,0x2,0x3,0x4 back-to-back -> writes to addr 0..3 on consecutive cycles; done=1 and err=0 after 4 cycles (8 cycles with verify on); core_hold drops.
REQ-033 word_count=3 with s_valid gapped 2 cycles between beats -> exactly 3 writes, no write during gaps, addr 0..2.
REQ-034 word_count=0, then word_count=65 -> each gives DONE with err=1, zero writes, core_hold=1.
REQ-035 Verify on; memory model corrupts addr 1 after write -> DONE with err=1, core_hold=1.
REQ-036 rst_n pulled low after 2 of 8 beats -> all outputs at reset values asynchronously; a fresh start of 8 words then completes with err=0.
REQ-037 word_count=64 full load of 0xFFFFFFFF -> last write at addr 63, no wrap; checksum 0xFFFFFFC0 matches; err=0.
